// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Sequential front end of the 8-bit CPU. Owns the program counter and the
// instruction register, fetches 1- or 2-byte instructions from program memory
// over a req/ack handshake, and presents opcode/register/immediate fields to
// the combinational control unit while in EXEC.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req          fetch request, high in FETCH1/FETCH2
//   imem_addr [7:0]   fetch address (current pc)
//   imem_ack          memory accepted the request; imem_rdata valid this cycle
//   imem_rdata [7:0]  instruction byte from memory
//   opcode [3:0]      IR[7:4] in EXEC, else 0
//   reg_sel [3:0]     IR[3:0] in EXEC, else 0
//   imm [7:0]         second instruction byte in EXEC (0 for 1-byte), else 0
//   exec_valid        high only in EXEC
//   pc_en             control: retire and fall through
//   pc_load           control: retire and branch to imm (wins over pc_en)
//   ir_load           control: permit loading the next instruction
//   pc [7:0]          current pc (observability)
//   retired_cnt[15:0] retired-instruction counter (only with IFU_RETIRE_CNT_EN)
//
// Optional feature macro: IFU_RETIRE_CNT_EN
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [7:0]  RESET_PC      = 8'h00,
  parameter logic [15:0] TWO_BYTE_MASK = 16'h03E2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  output logic [3:0]  opcode,
  output logic [3:0]  reg_sel,
  output logic [7:0]  imm,
  output logic        exec_valid,
  input  logic        pc_en,
  input  logic        pc_load,
  input  logic        ir_load,
`ifdef IFU_RETIRE_CNT_EN
  output logic [15:0] retired_cnt,
`endif
  output logic [7:0]  pc
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH1 = 2'd1;
  localparam logic [1:0] FETCH2 = 2'd2;
  localparam logic [1:0] EXEC   = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] pc_q,    pc_d;
  logic [7:0] ir_q,    ir_d;
  logic [7:0] imm_q,   imm_d;
  logic       retire;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    retire  = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH1;

      FETCH1: begin
        if (imem_ack) begin
          ir_d = imem_rdata;
          pc_d = pc_q + 8'd1;
          // The mask bit for the fetched opcode decides whether a second
          // byte follows; 1-byte instructions present imm as zero.
          if (TWO_BYTE_MASK[imem_rdata[7:4]]) begin
            state_d = FETCH2;
          end else begin
            imm_d   = 8'h00;
            state_d = EXEC;
          end
        end
      end

      FETCH2: begin
        if (imem_ack) begin
          imm_d   = imem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = EXEC;
        end
      end

      EXEC: begin
        // pc already points past the instruction, so fall-through only
        // changes state; a branch overwrites pc with the immediate.
        if (ir_load && pc_load) begin
          pc_d    = imm_q;
          state_d = FETCH1;
          retire  = 1'b1;
        end else if (ir_load && pc_en) begin
          state_d = FETCH1;
          retire  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

`ifdef IFU_RETIRE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'h0000;
    else        cnt_q <= cnt_d;
  end

  assign retired_cnt = cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  // Outputs decode registered state only: no input-to-output path.
  assign exec_valid = (state_q == EXEC);
  assign imem_req   = (state_q == FETCH1) || (state_q == FETCH2);
  assign imem_addr  = pc_q;
  assign opcode     = exec_valid ? ir_q[7:4] : 4'h0;
  assign reg_sel    = exec_valid ? ir_q[3:0] : 4'h0;
  assign imm        = exec_valid ? imm_q     : 8'h00;
  assign pc         = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit: a 256-byte program memory model with
// bench-controlled ack, and a linear sequence of steps with hand-computed
// expectations. Retired-counter checks are compiled in with IFU_RETIRE_CNT_EN.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic [3:0]  opcode;
  logic [3:0]  reg_sel;
  logic [7:0]  imm;
  logic        exec_valid;
  logic        pc_en;
  logic        pc_load;
  logic        ir_load;
  logic [7:0]  pc;
`ifdef IFU_RETIRE_CNT_EN
  logic [15:0] retired_cnt;
`endif

  logic [7:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Program memory: returns the byte at the requested address.
  assign imem_rdata = mem[imem_addr];

  instr_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .opcode     (opcode),
    .reg_sel    (reg_sel),
    .imm        (imm),
    .exec_valid (exec_valid),
    .pc_en      (pc_en),
    .pc_load    (pc_load),
    .ir_load    (ir_load),
`ifdef IFU_RETIRE_CNT_EN
    .retired_cnt(retired_cnt),
`endif
    .pc         (pc)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; imem_ack = 1'b1; pc_en = 1'b1; pc_load = 1'b0; ir_load = 1'b1;
    #12;
    // ---- reset state ----
    check("rst_req",   {15'd0, imem_req},   16'h0);
    check("rst_pc",    {8'd0, pc},          16'h00);
    check("rst_exec",  {15'd0, exec_valid}, 16'h0);
    check("rst_op",    {12'd0, opcode},     16'h0);
    check("rst_imm",   {8'd0, imm},         16'h00);
`ifdef IFU_RETIRE_CNT_EN
    check("rst_cnt",   retired_cnt,         16'h0000);
`endif

    // ---- NOP at 00, zero wait ----
    @(negedge clk); rst_n = 1'b1;
    tick(); // IDLE -> FETCH1
    check("nop_req",   {15'd0, imem_req},   16'h1);
    check("nop_addr",  {8'd0, imem_addr},   16'h00);
    tick(); // FETCH1 -> EXEC
    check("nop_exec",  {15'd0, exec_valid}, 16'h1);
    check("nop_op",    {12'd0, opcode},     16'h0);
    check("nop_pc",    {8'd0, pc},          16'h01);
    check("nop_noreq", {15'd0, imem_req},   16'h0);
    tick(); // EXEC -> FETCH1 @01
    check("nop_next",  {8'd0, imem_addr},   16'h01);
    check("nop_req2",  {15'd0, imem_req},   16'h1);
`ifdef IFU_RETIRE_CNT_EN
    check("nop_cnt",   retired_cnt,         16'h0001);
`endif

    // ---- program image for the remaining steps ----
    mem[8'h00] = 8'h12; mem[8'h01] = 8'hA5; // LDI r2,#A5
    mem[8'h04] = 8'h50; mem[8'h05] = 8'h20; // JMP 20
    mem[8'h20] = 8'h50; mem[8'h21] = 8'h30; // JMP 30
    mem[8'h30] = 8'hF3;                     // replaced before ack
    mem[8'h31] = 8'h50; mem[8'h32] = 8'hFF; // JMP FF
    mem[8'hFF] = 8'h60;                     // JZ with second byte at 00
    reset_dut();
`ifdef IFU_RETIRE_CNT_EN
    check("rst2_cnt",  retired_cnt,         16'h0000);
`endif

    // ---- LDI r2,#A5 ----
    tick(); // FETCH1 @00
    check("ldi_f1",    {8'd0, imem_addr},   16'h00);
    tick(); // FETCH2 @01
    check("ldi_f2",    {8'd0, imem_addr},   16'h01);
    check("ldi_f2req", {15'd0, imem_req},   16'h1);
    check("ldi_f2imm", {8'd0, imm},         16'h00);
    tick(); // EXEC
    check("ldi_op",    {12'd0, opcode},     16'h1);
    check("ldi_reg",   {12'd0, reg_sel},    16'h2);
    check("ldi_imm",   {8'd0, imm},         16'hA5);
    check("ldi_pc",    {8'd0, pc},          16'h02);
    tick(); // FETCH1 @02
    check("ldi_next",  {8'd0, imem_addr},   16'h02);
    tick(); tick(); tick(); // NOP@02 EXEC, FETCH1@03, NOP@03 EXEC
    check("nop3_imm",  {8'd0, imm},         16'h00);
    tick(); // FETCH1 @04

    // ---- JMP 20 with pc_load ----
    check("jmp_f1",    {8'd0, imem_addr},   16'h04);
    tick(); tick(); // FETCH2 @05, EXEC
    check("jmp_op",    {12'd0, opcode},     16'h5);
    check("jmp_imm",   {8'd0, imm},         16'h20);
    check("jmp_pc",    {8'd0, pc},          16'h06);
    pc_load = 1'b1; pc_en = 1'b0;
    tick();
    check("jmp_tgt",   {8'd0, imem_addr},   16'h20);
    pc_load = 1'b0; pc_en = 1'b1;
    tick(); tick(); // FETCH2 @21, EXEC imm=30
    check("jmp2_imm",  {8'd0, imm},         16'h30);
    pc_load = 1'b1; pc_en = 1'b1; // pc_load has priority
    tick();
    check("jmp2_tgt",  {8'd0, imem_addr},   16'h30);
    pc_load = 1'b0;

    // ---- 3 wait cycles at 30 ----
    imem_ack = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      check("wait_req",  {15'd0, imem_req},   16'h1);
      check("wait_addr", {8'd0, imem_addr},   16'h30);
      check("wait_exec", {15'd0, exec_valid}, 16'h0);
    end
    mem[8'h30] = 8'hA4; // undefined opcode 10, 1-byte
    imem_ack = 1'b1;
    tick(); // EXEC
    check("wait_op",   {12'd0, opcode},     16'hA);
    check("wait_reg",  {12'd0, reg_sel},    16'h4);
    check("wait_imm",  {8'd0, imm},         16'h00);
    check("wait_pc",   {8'd0, pc},          16'h31);
    tick(); // FETCH1 @31

    // ---- JMP FF, then 2-byte instruction across the wrap ----
    tick(); tick(); // FETCH2 @32, EXEC imm=FF
    pc_load = 1'b1;
    tick();
    check("wrap_f1",   {8'd0, imem_addr},   16'hFF);
    pc_load = 1'b0;
    mem[8'h00] = 8'h33;
    tick(); // FETCH2 @00
    check("wrap_f2",   {8'd0, imem_addr},   16'h00);
    tick(); // EXEC
    check("wrap_op",   {12'd0, opcode},     16'h6);
    check("wrap_imm",  {8'd0, imm},         16'h33);
    check("wrap_pc",   {8'd0, pc},          16'h01);

    // ---- stall: neither retire request, then pc_en without ir_load ----
    pc_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      check("stall_exec", {15'd0, exec_valid}, 16'h1);
      check("stall_req",  {15'd0, imem_req},   16'h0);
      check("stall_imm",  {8'd0, imm},         16'h33);
      check("stall_pc",   {8'd0, pc},          16'h01);
    end
    pc_en = 1'b1; ir_load = 1'b0;
    tick();
    check("noirl_exec", {15'd0, exec_valid}, 16'h1);
`ifdef IFU_RETIRE_CNT_EN
    check("stall_cnt",  retired_cnt,         16'h0007);
`endif
    ir_load = 1'b1;
    tick(); // FETCH1 @01
    check("resume_addr", {8'd0, imem_addr}, 16'h01);
`ifdef IFU_RETIRE_CNT_EN
    check("resume_cnt",  retired_cnt,       16'h0008);
`endif

    // ---- reset mid-FETCH2 ----
    mem[8'h01] = 8'h12;
    tick(); // FETCH2 @02
    check("mid_f2req", {15'd0, imem_req},   16'h1);
    check("mid_f2adr", {8'd0, imem_addr},   16'h02);
    #2 rst_n = 1'b0;
    #1;
    check("mid_req",   {15'd0, imem_req},   16'h0);
    check("mid_pc",    {8'd0, pc},          16'h00);
    check("mid_exec",  {15'd0, exec_valid}, 16'h0);
`ifdef IFU_RETIRE_CNT_EN
    check("mid_cnt",   retired_cnt,         16'h0000);
`endif
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("rest_req",  {15'd0, imem_req},   16'h1);
    check("rest_addr", {8'd0, imem_addr},   16'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
